// File: rtl/alu_pipe_if.sv
// Handshake bundle for alu_pipe: operand issue side (in_*) and writeback side (out_*, result, flags).
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] operand1;
    logic [WIDTH-1:0] operand2;
    logic [3:0]       opcode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   result;
    logic [TAG_W-1:0] out_tag;
    logic             flag_zero;
    logic             flag_neg;
    logic             flag_ovf;
    logic             flag_illegal;

    modport master (
        output in_valid, operand1, operand2, opcode, in_tag, out_ready,
        input  in_ready, out_valid, result, out_tag,
        input  flag_zero, flag_neg, flag_ovf, flag_illegal
    );

    modport slave (
        input  in_valid, operand1, operand2, opcode, in_tag, out_ready,
        output in_ready, out_valid, result, out_tag,
        output flag_zero, flag_neg, flag_ovf, flag_illegal
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU with valid/ready on both sides, tag passthrough and status flags.
// Define ALU_MUL_EN to build the unsigned multiply on opcode 1011; otherwise that opcode is illegal.
module alu_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned TAG_W = 4
) (
    input logic        clock,
    input logic        reset_n,
    alu_pipe_if.slave  bus
);
    localparam int unsigned SHW = $clog2(WIDTH);

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLT  = 4'b1001;
    localparam logic [3:0] OP_SLTU = 4'b1010;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'b1011;
`endif

    logic             s1_valid;
    logic [WIDTH-1:0] s1_op1;
    logic [WIDTH-1:0] s1_op2;
    logic [3:0]       s1_opcode;
    logic [TAG_W-1:0] s1_tag;

    logic             s1_en;
    logic             s2_en;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic             sh_big;
    logic [SHW-1:0]   sh_amt;
    logic [WIDTH-1:0] val;
    logic             hi;
    logic             ovf;
    logic             illegal;
`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = {{WIDTH{1'b0}}, s1_op1} * {{WIDTH{1'b0}}, s1_op2};
`endif

    // Downstream stage frees when empty or draining; in_ready never looks at in_valid.
    assign s2_en       = !bus.out_valid || bus.out_ready;
    assign s1_en       = !s1_valid || s2_en;
    assign bus.in_ready = reset_n && s1_en;

    assign sum    = {1'b0, s1_op1} + {1'b0, s1_op2};
    assign diff   = {1'b0, s1_op1} - {1'b0, s1_op2};
    assign sh_big = s1_op2 >= WIDTH'(WIDTH);
    assign sh_amt = s1_op2[SHW-1:0];

    // Stage-2 datapath: value, carry/borrow bit and signed-overflow for the op held in stage 1.
    always_comb begin
        val     = '0;
        hi      = 1'b0;
        ovf     = 1'b0;
        illegal = 1'b0;
        case (s1_opcode)
            OP_ADD: begin
                {hi, val} = sum;
                ovf = (s1_op1[WIDTH-1] == s1_op2[WIDTH-1]) && (sum[WIDTH-1] != s1_op1[WIDTH-1]);
            end
            OP_SUB: begin
                {hi, val} = diff;
                ovf = (s1_op1[WIDTH-1] != s1_op2[WIDTH-1]) && (diff[WIDTH-1] != s1_op1[WIDTH-1]);
            end
            OP_AND:  val = s1_op1 & s1_op2;
            OP_OR:   val = s1_op1 | s1_op2;
            OP_XOR:  val = s1_op1 ^ s1_op2;
            OP_SLL:  val = sh_big ? '0 : (s1_op1 << sh_amt);
            OP_SRL:  val = sh_big ? '0 : (s1_op1 >> sh_amt);
            OP_SRA:  val = sh_big ? {WIDTH{s1_op1[WIDTH-1]}}
                                  : WIDTH'(unsigned'($signed(s1_op1) >>> sh_amt));
            OP_SLT:  val = {{(WIDTH-1){1'b0}}, ($signed(s1_op1) < $signed(s1_op2))};
            OP_SLTU: val = {{(WIDTH-1){1'b0}}, (s1_op1 < s1_op2)};
`ifdef ALU_MUL_EN
            OP_MUL: begin
                val = prod[WIDTH-1:0];
                hi  = |prod[2*WIDTH-1:WIDTH];
            end
`endif
            default: illegal = 1'b1;
        endcase
    end

    // Stage 1: operand capture.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid  <= 1'b0;
            s1_op1    <= '0;
            s1_op2    <= '0;
            s1_opcode <= '0;
            s1_tag    <= '0;
        end else if (s1_en) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_op1    <= bus.operand1;
                s1_op2    <= bus.operand2;
                s1_opcode <= bus.opcode;
                s1_tag    <= bus.in_tag;
            end
        end
    end

    // Stage 2: registered result, tag and flags; holds while the consumer stalls.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            bus.out_valid    <= 1'b0;
            bus.result       <= '0;
            bus.out_tag      <= '0;
            bus.flag_zero    <= 1'b0;
            bus.flag_neg     <= 1'b0;
            bus.flag_ovf     <= 1'b0;
            bus.flag_illegal <= 1'b0;
        end else if (s2_en) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
                bus.result       <= {hi, val};
                bus.out_tag      <= s1_tag;
                bus.flag_zero    <= (val == '0);
                bus.flag_neg     <= val[WIDTH-1];
                bus.flag_ovf     <= ovf;
                bus.flag_illegal <= illegal;
            end
        end
    end
endmodule
